uint_add_accum: RTL and testbench
=================================

Name: uint_add_accum

Overview:
- Parametrised, registered successor to the combinational unsigned adder.
- Adds two WIDTH-bit unsigned operands, or adds one operand into an internal accumulator.
- Wrap or saturate on overflow; exposes carry-out.
- Ready/valid on input and output, single output register stage; sits between magma-generated datapath stages.

Parameters:
- WIDTH, 3, operand/result width in bits (>=1)
- SATURATE, 0, 1 = clamp result to all-ones on carry; 0 = wrap modulo 2^WIDTH
- ACC_INIT, 0, accumulator value after reset (WIDTH bits)

Ports:
- CLK  input  1  clock, rising edge
- ASYNCRESET  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands/mode valid
- in_ready  output  1  block can accept this cycle
- I0  input  WIDTH  operand 0
- I1  input  WIDTH  operand 1 (ignored in ACCUM and LOAD)
- mode  input  2  00 ADD, 01 ACCUM, 10 LOAD, 11 reserved (behaves as ADD)
- out_valid  output  1  O/COUT valid
- out_ready  input  1  downstream accepts
- O  output  WIDTH  registered result
- COUT  output  1  registered carry/overflow flag
- acc  output  WIDTH  current accumulator value (registered)

Behaviour:
- Reset (asynchronous, immediate on ASYNCRESET=1):
  - O=0, COUT=0, out_valid=0, acc=ACC_INIT.
  - An in-flight or stalled result is discarded.
  - in_ready=1 as soon as reset deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
  - accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Latency: accepted operands appear on O/COUT with out_valid=1 at the next rising edge (1 cycle).
- Throughput: one result per cycle when out_ready is held at 1. Accept and output transfer in the same cycle replace the output register; there is no bubble.
- Stall: while out_valid && !out_ready, O, COUT, out_valid and acc hold.
- No accept and transfer occurs: out_valid goes to 0 next cycle; O/COUT hold their last value.
- Arithmetic: full sum S = {1'b0,A} + {1'b0,B} (WIDTH+1 bits); carry = S[WIDTH].
  - ADD/reserved: A=I0, B=I1; acc unchanged.
  - ACCUM: A=acc, B=I0; acc <= result on accept.
  - LOAD: result=I0, carry=0; acc <= I0.
  - Result = S[WIDTH-1:0] when SATURATE=0 or carry=0, else all-ones.
  - COUT = carry in every mode except LOAD (COUT=1 even when saturated).
- ACCUM uses the acc value registered before the accepting edge. Back-to-back ACCUM accepts chain correctly: each accept sees the previous accept's update.
- acc output always equals the accumulator register; it updates on the same edge as O.
- mode, I0 and I1 are sampled only on accept. Values presented without accept have no effect.

Decomposition:
- Package uint_add_pkg:
  - mode encodings MODE_ADD=2'b00, MODE_ACCUM=2'b01, MODE_LOAD=2'b10, MODE_RSVD=2'b11;
  - helper width constant for the WIDTH+1 sum.
- Sub-module uint_add_carry:
  - combinational, parameter WIDTH, ports in0, in1 (WIDTH), out (WIDTH), cout (1);
  - generalised successor of the plain add primitive.
- Top holds the mode mux, saturation mux, output/accumulator registers and handshake.

Test Plan:
- WIDTH=3, SATURATE=0, out_ready=1: ADD I0=3, I1=2 -> next cycle O=5, COUT=0, out_valid=1; no further input -> out_valid=0 following cycle.
- WIDTH=3, SATURATE=0: ADD I0=6, I1=5 -> O=3, COUT=1. Same stimulus with SATURATE=1 -> O=7, COUT=1.
- WIDTH=3, ACC_INIT=0: back-to-back ACCUM I0=3, 3, 3 on consecutive cycles -> O/acc = 3, 6, 1 and COUT = 0, 0, 1. Then LOAD I0=4 -> O=4, acc=4, COUT=0. Then ADD 1+1 -> O=2, acc stays 4.
- Backpressure: ADD 1+1 accepted, out_ready=0 for 3 cycles with in_valid=1, I0=2, I1=2 -> in_ready=0; O=2 held; second op not consumed. out_ready=1 -> that cycle accepts, next cycle O=4.
- Simultaneous transfer+accept: out_valid=1, out_ready=1, in_valid=1 ADD 7+0 -> in_ready=1; next cycle O=7, out_valid stays 1.
- Reset mid-stall: out_valid=1, out_ready=0, acc=5; assert ASYNCRESET between edges -> O=0, COUT=0, out_valid=0, acc=ACC_INIT immediately. After release, in_ready=1 and the first ACCUM I0=1 gives O=ACC_INIT+1.

Source files
------------

// File: rtl/uint_add_pkg.sv
// Shared encodings and sizing helpers for the registered unsigned adder/accumulator.
package uint_add_pkg;

  // Operation select carried on the mode input.
  localparam logic [1:0] MODE_ADD   = 2'b00;
  localparam logic [1:0] MODE_ACCUM = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    OP_ADD   = MODE_ADD,
    OP_ACCUM = MODE_ACCUM,
    OP_LOAD  = MODE_LOAD,
    OP_RSVD  = MODE_RSVD
  } op_mode_e;

  // Width of the full sum including the carry bit.
  function automatic int sum_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/uint_add_carry.sv
// Combinational WIDTH-bit unsigned adder exposing the carry-out.
module uint_add_carry
  import uint_add_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  localparam int SUM_W = sum_width(WIDTH);

  logic [SUM_W-1:0] w_sum;

  assign w_sum = {1'b0, in0} + {1'b0, in1};
  assign out   = w_sum[WIDTH-1:0];
  assign cout  = w_sum[WIDTH];

endmodule

// File: rtl/uint_add_accum.sv
// Registered unsigned add / accumulate stage with ready/valid on both sides.
// One output register; a new operand set may be accepted in the same cycle
// the current result is taken, so full throughput needs no skid buffer.
module uint_add_accum
  import uint_add_pkg::*;
#(
  parameter int               WIDTH    = 3,
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] r_o;
  logic             r_cout;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_acc;

  op_mode_e         w_mode;
  logic             w_accept;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_sum_cout;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_acc_upd;

  // Ready only depends on the output register, never on in_valid.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_mode   = op_mode_e'(mode);

  // Operand select: ACCUM adds I0 into the accumulator, everything else adds I0+I1.
  always_comb begin
    w_op_a    = I0;
    w_op_b    = I1;
    w_acc_upd = 1'b0;
    case (w_mode)
      OP_ACCUM: begin
        w_op_a    = r_acc;
        w_op_b    = I0;
        w_acc_upd = 1'b1;
      end
      OP_LOAD: begin
        w_acc_upd = 1'b1;
      end
      default: begin
        w_op_a = I0;
        w_op_b = I1;
      end
    endcase
  end

  uint_add_carry #(
    .WIDTH (WIDTH)
  ) u_add (
    .in0  (w_op_a),
    .in1  (w_op_b),
    .out  (w_sum),
    .cout (w_sum_cout)
  );

  // Result select: LOAD passes I0 with no carry; otherwise wrap or clamp on carry.
  always_comb begin
    w_result = w_sum;
    w_carry  = w_sum_cout;
    if (w_mode == OP_LOAD) begin
      w_result = I0;
      w_carry  = 1'b0;
    end else if (SATURATE && w_sum_cout) begin
      w_result = '1;
    end
  end

  // Output and accumulator registers; stalled results hold, reset drops them.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_o         <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_acc       <= ACC_INIT;
    end else if (w_accept) begin
      r_o         <= w_result;
      r_cout      <= w_carry;
      r_out_valid <= 1'b1;
      if (w_acc_upd) begin
        r_acc <= w_result;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign O         = r_o;
  assign COUT      = r_cout;
  assign out_valid = r_out_valid;
  assign acc       = r_acc;

endmodule

// File: tb/tb_uint_add_accum.sv
// Directed bench: a wrapping instance (ACC_INIT=0) and a saturating instance
// (ACC_INIT=2) share one stimulus stream.
module tb_uint_add_accum;

  logic       CLK = 1'b0;
  logic       ASYNCRESET;
  logic       in_valid;
  logic [2:0] I0;
  logic [2:0] I1;
  logic [1:0] mode;
  logic       out_ready;

  logic       w_in_ready, w_out_valid, w_cout;
  logic [2:0] w_o, w_acc;
  logic       s_in_ready, s_out_valid, s_cout;
  logic [2:0] s_o, s_acc;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  uint_add_accum #(.WIDTH(3), .SATURATE(1'b0), .ACC_INIT(3'd0)) dut_wrap (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .in_valid(in_valid), .in_ready(w_in_ready),
    .I0(I0), .I1(I1), .mode(mode), .out_valid(w_out_valid), .out_ready(out_ready),
    .O(w_o), .COUT(w_cout), .acc(w_acc)
  );

  uint_add_accum #(.WIDTH(3), .SATURATE(1'b1), .ACC_INIT(3'd2)) dut_sat (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .in_valid(in_valid), .in_ready(s_in_ready),
    .I0(I0), .I1(I1), .mode(mode), .out_valid(s_out_valid), .out_ready(out_ready),
    .O(s_o), .COUT(s_cout), .acc(s_acc)
  );

  typedef struct {
    logic       vld;
    logic [1:0] md;
    logic [2:0] a;
    logic [2:0] b;
    logic       e_ov;
    logic [2:0] e_o;
    logic       e_c;
    logic [2:0] e_acc;
    logic [2:0] e_os;
    logic       e_cs;
    logic [2:0] e_accs;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [2:0] a,
                       input logic [2:0] b, input logic r);
    in_valid  = v;
    mode      = m;
    I0        = a;
    I1        = b;
    out_ready = r;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //            vld  md     a     b    ov  O     C   acc  | Os   Cs  accs
    vecs[0]  = '{1'b1, 2'b00, 3'd3, 3'd2, 1, 3'd5, 0, 3'd0, 3'd5, 0, 3'd2};
    vecs[1]  = '{1'b0, 2'b00, 3'd0, 3'd0, 0, 3'd5, 0, 3'd0, 3'd5, 0, 3'd2};
    vecs[2]  = '{1'b1, 2'b00, 3'd6, 3'd5, 1, 3'd3, 1, 3'd0, 3'd7, 1, 3'd2};
    vecs[3]  = '{1'b1, 2'b01, 3'd3, 3'd0, 1, 3'd3, 0, 3'd3, 3'd5, 0, 3'd5};
    vecs[4]  = '{1'b1, 2'b01, 3'd3, 3'd0, 1, 3'd6, 0, 3'd6, 3'd7, 1, 3'd7};
    vecs[5]  = '{1'b1, 2'b01, 3'd3, 3'd0, 1, 3'd1, 1, 3'd1, 3'd7, 1, 3'd7};
    vecs[6]  = '{1'b1, 2'b10, 3'd4, 3'd7, 1, 3'd4, 0, 3'd4, 3'd4, 0, 3'd4};
    vecs[7]  = '{1'b1, 2'b00, 3'd1, 3'd1, 1, 3'd2, 0, 3'd4, 3'd2, 0, 3'd4};
    vecs[8]  = '{1'b1, 2'b00, 3'd7, 3'd0, 1, 3'd7, 0, 3'd4, 3'd7, 0, 3'd4};
    vecs[9]  = '{1'b0, 2'b01, 3'd5, 3'd0, 0, 3'd7, 0, 3'd4, 3'd7, 0, 3'd4};
    vecs[10] = '{1'b1, 2'b11, 3'd7, 3'd7, 1, 3'd6, 1, 3'd4, 3'd7, 1, 3'd4};
    vecs[11] = '{1'b1, 2'b01, 3'd7, 3'd0, 1, 3'd3, 1, 3'd3, 3'd7, 1, 3'd7};

    ASYNCRESET = 1'b1;
    drive(1'b0, 2'b00, 3'd0, 3'd0, 1'b1);
    step();
    step();
    ASYNCRESET = 1'b0;
    #1;
    chk("rst_o", w_o, 0);
    chk("rst_cout", w_cout, 0);
    chk("rst_out_valid", w_out_valid, 0);
    chk("rst_acc", w_acc, 0);
    chk("rst_acc_sat", s_acc, 2);
    chk("rst_in_ready", w_in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].vld, vecs[i].md, vecs[i].a, vecs[i].b, 1'b1);
      #1;
      chk($sformatf("v%0d_in_ready", i), w_in_ready, 1);
      chk($sformatf("v%0d_in_ready_sat", i), s_in_ready, 1);
      step();
      chk($sformatf("v%0d_out_valid", i), w_out_valid, vecs[i].e_ov);
      chk($sformatf("v%0d_o", i), w_o, vecs[i].e_o);
      chk($sformatf("v%0d_cout", i), w_cout, vecs[i].e_c);
      chk($sformatf("v%0d_acc", i), w_acc, vecs[i].e_acc);
      chk($sformatf("v%0d_o_sat", i), s_o, vecs[i].e_os);
      chk($sformatf("v%0d_cout_sat", i), s_cout, vecs[i].e_cs);
      chk($sformatf("v%0d_acc_sat", i), s_acc, vecs[i].e_accs);
    end

    // Backpressure: result 2 stalls while a second ADD waits at the input.
    drive(1'b1, 2'b00, 3'd1, 3'd1, 1'b1);
    step();
    chk("bp_first_o", w_o, 2);
    drive(1'b1, 2'b00, 3'd2, 3'd2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), w_in_ready, 0);
      step();
      chk($sformatf("bp%0d_o", c), w_o, 2);
      chk($sformatf("bp%0d_out_valid", c), w_out_valid, 1);
      chk($sformatf("bp%0d_acc", c), w_acc, 3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", w_in_ready, 1);
    step();
    chk("bp_release_o", w_o, 4);
    chk("bp_release_out_valid", w_out_valid, 1);

    // Reset in the middle of a stall with acc=5.
    drive(1'b1, 2'b10, 3'd5, 3'd0, 1'b1);
    step();
    chk("pre_rst_acc", w_acc, 5);
    drive(1'b0, 2'b00, 3'd0, 3'd0, 1'b0);
    step();
    chk("pre_rst_stall_ov", w_out_valid, 1);
    chk("pre_rst_stall_o", w_o, 5);
    #3;
    ASYNCRESET = 1'b1;
    #1;
    chk("mid_rst_o", w_o, 0);
    chk("mid_rst_cout", w_cout, 0);
    chk("mid_rst_out_valid", w_out_valid, 0);
    chk("mid_rst_acc", w_acc, 0);
    chk("mid_rst_acc_sat", s_acc, 2);
    #1;
    ASYNCRESET = 1'b0;
    #1;
    chk("post_rst_in_ready", w_in_ready, 1);
    drive(1'b1, 2'b01, 3'd1, 3'd0, 1'b0);
    step();
    chk("post_rst_o", w_o, 1);
    chk("post_rst_acc", w_acc, 1);
    chk("post_rst_out_valid", w_out_valid, 1);
    chk("post_rst_o_sat", s_o, 3);
    chk("post_rst_acc_sat", s_acc, 3);
    drive(1'b0, 2'b00, 3'd0, 3'd0, 1'b1);
    step();
    chk("final_out_valid", w_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
